tx_block_sync_mux: RTL and testbench

//  Stage directly downstream of the TX framing FSM. Owns the 128b/130b symbol counter (0..15) fed back to framing,

---
 rtl/tx_block_sync_mux.sv | 124 ++++++++++++
 tb/tb_tx_block_sync_mux.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_block_sync_mux.sv
// Symbol-row mux downstream of TX framing: owns the 128b/130b symbol counter,
// selects framed / ordered-set / idle rows and attaches the block sync header.
module tx_block_sync_mux #(
   parameter int SYMBOL_WIDTH     = 8,
   parameter int SYMBOL_PTR_WIDTH = 5,
   parameter int MAX_LANES        = 2**SYMBOL_PTR_WIDTH,
   parameter int SYMBOL_NUM_WIDTH = 4
) (
   input  logic                              CLK,
   input  logic                              RST_L,
   input  logic                              i_EN,
   input  logic [SYMBOL_WIDTH*MAX_LANES-1:0] i_Framed_Data,
   input  logic [1:0]                        i_Fram_Sel,
   input  logic                              i_Sync_Sel,
   input  logic [SYMBOL_WIDTH*MAX_LANES-1:0] i_Os_Data,
   input  logic                              i_Os_Valid,
   input  logic [SYMBOL_WIDTH-1:0]           i_IDL,
   input  logic                              i_Err_Clr,
   output logic [SYMBOL_NUM_WIDTH-1:0]       o_Symbol_Num,
   output logic                              o_Os_R_EN,
   output logic [SYMBOL_WIDTH*MAX_LANES-1:0] o_Lane_Data,
   output logic [1:0]                        o_Sync_Header,
   output logic                              o_Block_Start,
   output logic                              o_Valid,
   output logic [SYMBOL_NUM_WIDTH-1:0]       o_Out_Sym,
   output logic                              o_Block_Err,
   output logic                              o_Os_Underflow
);

   localparam int ROW_W = SYMBOL_WIDTH*MAX_LANES;
   localparam logic [SYMBOL_NUM_WIDTH-1:0] SYM_LAST = '1;

   localparam logic [1:0] SEL_IDLE = 2'b00;
   localparam logic [1:0] SEL_OS   = 2'b01;

   localparam logic [1:0] HDR_DATA = 2'b10;
   localparam logic [1:0] HDR_OS   = 2'b01;

   logic [SYMBOL_NUM_WIDTH-1:0] sym_cnt_reg;
   logic [SYMBOL_NUM_WIDTH-1:0] sym_cnt_next;
   logic                        blk_type_reg;
   logic                        at_sym0;
   logic                        eff_os;
   logic                        sel_framed;
   logic                        sel_os;
   logic                        blk_err_set;
   logic                        os_uf_set;
   logic [ROW_W-1:0]            idle_row;
   logic [ROW_W-1:0]            row_next;

   genvar gi;
   generate
      for (gi = 0; gi < MAX_LANES; gi++) begin : g_idle
         assign idle_row[gi*SYMBOL_WIDTH +: SYMBOL_WIDTH] = i_IDL;
      end
   endgenerate

   assign at_sym0      = (sym_cnt_reg == '0);
   assign sym_cnt_next = (sym_cnt_reg == SYM_LAST) ? '0 : sym_cnt_reg + 1'b1;
   assign o_Symbol_Num = sym_cnt_reg;

   // Block type is taken live from i_Sync_Sel only on the row that latches it.
   assign eff_os     = at_sym0 ? i_Sync_Sel : blk_type_reg;
   assign sel_framed = i_Fram_Sel[1];
   assign sel_os     = (i_Fram_Sel == SEL_OS);

   assign o_Os_R_EN   = i_EN && sel_os && i_Os_Valid;
   assign blk_err_set = i_EN && ((sel_os && !eff_os) || (sel_framed && eff_os));
   assign os_uf_set   = i_EN && sel_os && !i_Os_Valid;

   always_comb begin
      row_next = idle_row;
      if (sel_framed) begin
         row_next = i_Framed_Data;
      end else if (sel_os && i_Os_Valid) begin
         row_next = i_Os_Data;
      end else if (i_Fram_Sel == SEL_IDLE) begin
         row_next = idle_row;
      end
   end

   always_ff @(posedge CLK or negedge RST_L) begin
      if (!RST_L) begin
         sym_cnt_reg    <= '0;
         blk_type_reg   <= 1'b0;
         o_Lane_Data    <= '0;
         o_Sync_Header  <= 2'b00;
         o_Block_Start  <= 1'b0;
         o_Valid        <= 1'b0;
         o_Out_Sym      <= '0;
         o_Block_Err    <= 1'b0;
         o_Os_Underflow <= 1'b0;
      end else begin
         if (i_EN) begin
            sym_cnt_reg   <= sym_cnt_next;
            o_Lane_Data   <= row_next;
            o_Out_Sym     <= sym_cnt_reg;
            o_Block_Start <= at_sym0;
            o_Valid       <= 1'b1;
            if (at_sym0) begin
               blk_type_reg  <= i_Sync_Sel;
               o_Sync_Header <= i_Sync_Sel ? HDR_OS : HDR_DATA;
            end
         end else begin
            o_Valid       <= 1'b0;
            o_Block_Start <= 1'b0;
         end

         // A new violation in the same cycle as a clear keeps the flag set.
         if (blk_err_set) begin
            o_Block_Err <= 1'b1;
         end else if (i_Err_Clr) begin
            o_Block_Err <= 1'b0;
         end

         if (os_uf_set) begin
            o_Os_Underflow <= 1'b1;
         end else if (i_Err_Clr) begin
            o_Os_Underflow <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_tx_block_sync_mux.sv
// Scoreboard bench for tx_block_sync_mux: directed block scenarios followed by
// randomized rows, checked against a block-level reference model.
module tb_tx_block_sync_mux;

   localparam int ROW_W = 256;

   logic             CLK = 1'b0;
   logic             RST_L = 1'b0;
   logic             i_EN = 1'b0;
   logic [ROW_W-1:0] i_Framed_Data = '0;
   logic [1:0]       i_Fram_Sel = 2'b00;
   logic             i_Sync_Sel = 1'b0;
   logic [ROW_W-1:0] i_Os_Data = '0;
   logic             i_Os_Valid = 1'b0;
   logic [7:0]       i_IDL = 8'h00;
   logic             i_Err_Clr = 1'b0;
   logic [3:0]       o_Symbol_Num;
   logic             o_Os_R_EN;
   logic [ROW_W-1:0] o_Lane_Data;
   logic [1:0]       o_Sync_Header;
   logic             o_Block_Start;
   logic             o_Valid;
   logic [3:0]       o_Out_Sym;
   logic             o_Block_Err;
   logic             o_Os_Underflow;

   tx_block_sync_mux dut (
      .CLK            (CLK),
      .RST_L          (RST_L),
      .i_EN           (i_EN),
      .i_Framed_Data  (i_Framed_Data),
      .i_Fram_Sel     (i_Fram_Sel),
      .i_Sync_Sel     (i_Sync_Sel),
      .i_Os_Data      (i_Os_Data),
      .i_Os_Valid     (i_Os_Valid),
      .i_IDL          (i_IDL),
      .i_Err_Clr      (i_Err_Clr),
      .o_Symbol_Num   (o_Symbol_Num),
      .o_Os_R_EN      (o_Os_R_EN),
      .o_Lane_Data    (o_Lane_Data),
      .o_Sync_Header  (o_Sync_Header),
      .o_Block_Start  (o_Block_Start),
      .o_Valid        (o_Valid),
      .o_Out_Sym      (o_Out_Sym),
      .o_Block_Err    (o_Block_Err),
      .o_Os_Underflow (o_Os_Underflow)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [ROW_W-1:0] data;
      logic [3:0]       sym;
   } row_t;

   typedef struct {
      logic             valid;
      logic             start;
      logic [1:0]       hdr;
      logic             err;
      logic             uf;
      logic [ROW_W-1:0] last;
      logic [3:0]       last_sym;
   } stat_t;

   row_t  row_q[$];
   stat_t stat_q[$];

   int n_checks = 0;
   int n_pass   = 0;
   bit in_reset = 1'b1;
   bit done     = 1'b0;

   // Reference model: block position is just rows-since-reset modulo 16.
   int               m_rows = 0;
   bit               m_os   = 1'b0;
   logic [1:0]       m_hdr  = 2'b00;
   bit               m_err  = 1'b0;
   bit               m_uf   = 1'b0;
   logic [ROW_W-1:0] m_last = '0;
   logic [3:0]       m_last_sym = '0;

   task automatic check(input string name, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else n_pass++;
   endtask

   function automatic logic [ROW_W-1:0] rnd_row();
      logic [ROW_W-1:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic model_reset();
      m_rows = 0; m_os = 1'b0; m_hdr = 2'b00; m_err = 1'b0; m_uf = 1'b0;
      m_last = '0; m_last_sym = '0;
      row_q.delete();
      stat_q.delete();
   endtask

   // Apply inputs for the coming rising edge, check combinational outputs, predict.
   task automatic drive_cycle(input bit en, input logic [1:0] sel, input bit sync, input bit osv, input bit clr);
      int               sym;
      bit               os_type;
      bit               err_set;
      bit               uf_set;
      logic [ROW_W-1:0] exp_row;
      row_t             r;
      stat_t            s;
      i_EN = en; i_Fram_Sel = sel; i_Sync_Sel = sync; i_Os_Valid = osv; i_Err_Clr = clr;
      i_Framed_Data = rnd_row();
      i_Os_Data     = rnd_row();
      i_IDL         = 8'($urandom);
      #1;
      sym = m_rows % 16;
      check("symbol_num", 256'(o_Symbol_Num), 256'(sym));
      check("os_r_en", 256'(o_Os_R_EN), 256'(en && sel == 2'b01 && osv));
      err_set = 1'b0;
      uf_set  = 1'b0;
      if (en) begin
         os_type = (sym == 0) ? sync : m_os;
         if (sel >= 2'b10) exp_row = i_Framed_Data;
         else if (sel == 2'b01 && osv) exp_row = i_Os_Data;
         else exp_row = {32{i_IDL}};
         err_set = (sel == 2'b01 && !os_type) || (sel >= 2'b10 && os_type);
         uf_set  = (sel == 2'b01 && !osv);
         if (sym == 0) begin
            m_os  = sync;
            m_hdr = sync ? 2'b01 : 2'b10;
         end
         r.data = exp_row;
         r.sym  = 4'(sym);
         row_q.push_back(r);
         m_last = exp_row;
         m_last_sym = 4'(sym);
         m_rows++;
      end
      if (err_set) m_err = 1'b1; else if (clr) m_err = 1'b0;
      if (uf_set)  m_uf  = 1'b1; else if (clr) m_uf  = 1'b0;
      s.valid = en;
      s.start = en && (sym == 0);
      s.hdr   = m_hdr;
      s.err   = m_err;
      s.uf    = m_uf;
      s.last  = m_last;
      s.last_sym = m_last_sym;
      stat_q.push_back(s);
   endtask

   task automatic step(input bit en, input logic [1:0] sel, input bit sync, input bit osv, input bit clr);
      @(negedge CLK);
      drive_cycle(en, sel, sync, osv, clr);
   endtask

   task automatic release_reset();
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RST_L = 1'b1;
      drive_cycle(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
      in_reset = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge CLK);
      #3;
      in_reset = 1'b1;
      RST_L = 1'b0;
      #1;
      check("rst_lane_data", o_Lane_Data, '0);
      check("rst_valid", 256'(o_Valid), 256'(0));
      check("rst_block_start", 256'(o_Block_Start), 256'(0));
      check("rst_out_sym", 256'(o_Out_Sym), 256'(0));
      check("rst_header", 256'(o_Sync_Header), 256'(0));
      check("rst_block_err", 256'(o_Block_Err), 256'(0));
      check("rst_underflow", 256'(o_Os_Underflow), 256'(0));
      check("rst_symbol_num", 256'(o_Symbol_Num), 256'(0));
      model_reset();
      release_reset();
   endtask

   // Monitor: one status entry per cycle, one row entry per presented row.
   always @(negedge CLK) begin
      stat_t s;
      row_t  r;
      if (!in_reset && !done) begin
         if (stat_q.size() == 0) begin
            n_checks++;
            $display("FAIL stat_q: monitor found no expected status entry");
         end else begin
            s = stat_q.pop_front();
            check("valid", 256'(o_Valid), 256'(s.valid));
            check("block_start", 256'(o_Block_Start), 256'(s.start));
            check("sync_header", 256'(o_Sync_Header), 256'(s.hdr));
            check("block_err", 256'(o_Block_Err), 256'(s.err));
            check("os_underflow", 256'(o_Os_Underflow), 256'(s.uf));
            if (o_Valid) begin
               if (row_q.size() == 0) begin
                  n_checks++;
                  $display("FAIL row_q: row presented with nothing expected");
               end else begin
                  r = row_q.pop_front();
                  check("lane_data", o_Lane_Data, r.data);
                  check("out_sym", 256'(o_Out_Sym), 256'(r.sym));
                  $display("row sym=%0d start=%b hdr=%b err=%b uf=%b", o_Out_Sym, o_Block_Start,
                           o_Sync_Header, o_Block_Err, o_Os_Underflow);
               end
            end else begin
               check("hold_lane_data", o_Lane_Data, s.last);
               check("hold_out_sym", 256'(o_Out_Sym), 256'(s.last_sym));
            end
         end
      end
   end

   initial begin
      bit   en;
      logic [1:0] sel;
      release_reset();
      // Idle data blocks: 32 rows including the release row.
      repeat (31) step(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
      // Full OS block.
      repeat (16) step(1'b1, 2'b01, 1'b1, 1'b1, 1'b0);
      // Data block, Sync flips mid-block, OS selected at symbol 7.
      for (int s = 0; s < 16; s++)
         step(1'b1, (s == 7) ? 2'b01 : 2'b10, (s >= 5), 1'b1, 1'b0);
      // Enable gap at symbol 9.
      repeat (9) step(1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
      repeat (3) step(1'b0, 2'b11, 1'b0, 1'b0, 1'b0);
      repeat (7) step(1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
      // OS underflow in an OS block, then a clear pulse.
      repeat (4) step(1'b1, 2'b01, 1'b1, 1'b0, 1'b0);
      step(1'b1, 2'b00, 1'b0, 1'b0, 1'b1);
      repeat (11) step(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
      // Asynchronous reset at symbol 11.
      repeat (11) step(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
      do_reset();
      for (int i = 0; i < 800; i++) begin
         en  = ($urandom_range(7) != 0);
         sel = 2'($urandom_range(3));
         step(en, sel, 1'($urandom), ($urandom_range(3) != 0), ($urandom_range(15) == 0));
      end
      step(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
      @(negedge CLK);
      #2;
      check("row_q_drained", 256'(row_q.size()), 256'(0));
      check("stat_q_drained", 256'(stat_q.size()), 256'(0));
      done = 1'b1;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
